snow3g_ks_xor: RTL and testbench
================================

Name: snow3g_ks_xor

Overview:
- Downstream consumer of the SNOW_3G keystream: combines 32-bit keystream words with a message word stream by XOR to produce ciphertext or plaintext, in the style of UEA2/f8.
- Sits between the SNOW_3G generator output (keystream) and the data path.
- Buffers keystream words in a small FIFO and exerts backpressure on the generator.
- Handles a programmable message bit length and zeroes the unused tail bits of the final word.

Parameters:
- KS_DEPTH, 4, keystream FIFO depth in words; power of two, at least 2.
- LEN_W, 16, width of the message bit-length field.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a message; accepted only in IDLE.
- msg_len  input  LEN_W  message length in bits; sampled when start is accepted.
- ks_word  input  32  keystream word from SNOW_3G.
- ks_valid  input  1  ks_word is valid this cycle.
- ks_ready  output  1  FIFO accepts ks_word this cycle.
- in_data  input  32  message word; bit 31 is the first message bit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  in_data is consumed this cycle.
- out_data  output  32  in_data XOR keystream, tail-masked.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  out_data is the final word of the message.
- busy  output  1  high while not in IDLE.
- done  output  1  one-cycle pulse at message completion.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; FIFO empty; counters 0.
  - out_data=0, out_valid=0, out_last=0, ks_ready=0, in_ready=0, busy=0, done=0.
- Words per message: nwords = ceil(msg_len/32) = (msg_len+31)>>5, width LEN_W-4.
- Tail bits: tail = msg_len[4:0]. A final-word mask keeps the top `tail` bits; tail=0 means a full word.
- IDLE:
  - ks_ready=0, in_ready=0.
  - start with msg_len≠0 latches nwords and tail, then goes to RUN next cycle.
  - start with msg_len=0 pulses done on the next cycle and stays in IDLE.
- RUN:
  - ks_ready = FIFO not full. Push when ks_valid && ks_ready.
  - Word fire = in_valid && FIFO not empty && (!out_valid || out_ready) && words_issued < nwords. in_ready equals fire.
  - On fire:
    - Pop the FIFO head.
    - Register out_data = (in_data ^ head) & mask, where mask = all-ones except on the final word.
    - Set out_valid=1, set out_last=1 on the final word, increment words_issued.
  - Latency: 1 cycle from fire to out_valid.
  - Push and pop in the same cycle are both honoured, so occupancy is unchanged, including when the FIFO is full.
  - out_valid holds with stable out_data and out_last until out_ready is high. Without a new fire it then clears.
  - When the final word is accepted (out_valid && out_ready && out_last):
    - done=1 for 1 cycle; state to IDLE.
    - FIFO is flushed and surplus keystream is discarded.
    - out_valid and out_last clear.
- start while busy is ignored. msg_len is not resampled.
- FIFO pointers wrap modulo KS_DEPTH. A count of KS_DEPTH+1 states distinguishes full from empty.
- Reset mid-message aborts immediately with no done pulse. All outputs return to reset values.
- The upstream generator must be re-keyed or re-initialised per message. This block does no keystream generation.

Test Plan:
- Full words:
  - Stimulus: msg_len=64; ks words 0xA5A5A5A5, 0x0F0F0F0F; in words 0xFFFFFFFF, 0x12345678; out_ready=1.
  - Required: out 0x5A5A5A5A, then 0x1D3B5977 with out_last=1; done 1 cycle after the last handshake.
- Partial tail:
  - Stimulus: msg_len=40; ks 0x00000000, 0xFFFFFFFF; in 0x11111111, 0xFFFFFFFF.
  - Required: out 0x11111111, then 0x00000000 with out_last=1.
  - Second check, msg_len=33 with the same final inputs 0x0 ^ 0xFFFFFFFF: final out 0x80000000.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while ks_valid is held high.
  - Required: out_data stable; in_ready=0; FIFO fills to 4 and then ks_ready=0; after release the words emerge in order with no loss or duplication.
- Zero length and ignored start:
  - Stimulus: msg_len=0.
  - Required: done pulses and busy stays 0.
  - Stimulus: during RUN, a second start with msg_len=8.
  - Required: ignored; word count unchanged.
- Flush:
  - Stimulus: msg_len=32 with 4 keystream words buffered.
  - Required: after done, a new message with ks 0xDEADBEEF and in 0x0 outputs 0xDEADBEEF, not a stale word.
- Reset mid-operation:
  - Stimulus: rst_n=0 asynchronously after word 1 of a 3-word message.
  - Required: outputs 0 within the same cycle; no done; a following message behaves as from power-up.

Source files
------------

// File: rtl/snow3g_ks_xor.sv
// SNOW_3G keystream combiner: buffers keystream words in a small FIFO and XORs them
// with the message word stream, zeroing unused tail bits of the final word.
module snow3g_ks_xor #(
  parameter int unsigned KS_DEPTH = 4,
  parameter int unsigned LEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [31:0]      ks_word,
  input  logic             ks_valid,
  output logic             ks_ready,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PtrW = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(KS_DEPTH + 1);
  localparam int unsigned NwW  = LEN_W - 4;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  state_e          state_q, state_d;
  logic [NwW-1:0]  nwords_q, nwords_d;
  logic [NwW-1:0]  issued_q, issued_d;
  logic [4:0]      tail_q, tail_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic            done_q, done_d;

  logic [31:0]     ks_mem [KS_DEPTH];

  logic            running;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            fire;
  logic            is_final;
  logic            last_accept;
  logic [31:0]     head;
  logic [31:0]     tail_mask;
  logic [LEN_W:0]  len_round;
  logic [NwW-1:0]  nwords_start;

  // ceil(msg_len / 32) without losing the carry out of the rounding add
  assign len_round    = {1'b0, msg_len} + (LEN_W + 1)'(31);
  assign nwords_start = len_round[LEN_W:5];

  assign running     = (state_q == StRun);
  assign fifo_full   = (count_q == CntW'(KS_DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign head        = ks_mem[rd_ptr_q];
  assign is_final    = ((issued_q + NwW'(1)) == nwords_q);
  assign tail_mask   = (tail_q == 5'd0) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> tail_q);

  assign push        = running && ks_valid && !fifo_full;
  assign fire        = running && in_valid && !fifo_empty && (!out_valid_q || out_ready) &&
                       (issued_q < nwords_q);
  assign last_accept = running && out_valid_q && out_ready && out_last_q;

  assign ks_ready  = running && !fifo_full;
  assign in_ready  = fire;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = running;
  assign done      = done_q;

  always_comb begin
    state_d     = state_q;
    nwords_d    = nwords_q;
    issued_d    = issued_q;
    tail_d      = tail_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (msg_len != '0) begin
            nwords_d = nwords_start;
            tail_d   = msg_len[4:0];
            issued_d = '0;
            state_d  = StRun;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      StRun: begin
        if (push) begin
          wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (fire) begin
          rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        count_d = count_q + CntW'(push) - CntW'(fire);

        if (fire) begin
          out_data_d  = (in_data ^ head) & (is_final ? tail_mask : 32'hFFFF_FFFF);
          out_valid_d = 1'b1;
          out_last_d  = is_final;
          issued_d    = issued_q + NwW'(1);
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end

        // Final handshake: surplus keystream belongs to this message, so drop it.
        if (last_accept) begin
          state_d     = StIdle;
          done_d      = 1'b1;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          count_d     = '0;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      nwords_q    <= '0;
      issued_q    <= '0;
      tail_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nwords_q    <= nwords_d;
      issued_q    <= issued_d;
      tail_q      <= tail_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      ks_mem[wr_ptr_q] <= ks_word;
    end
  end

endmodule

// File: tb/tb_snow3g_ks_xor.sv
// Self-checking bench for snow3g_ks_xor: directed scenarios plus randomized messages,
// checked cycle by cycle against a queue-based reference model.
module tb_snow3g_ks_xor;
  localparam int KS_DEPTH = 4;
  localparam int LEN_W    = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] msg_len;
  logic [31:0]      ks_word;
  logic             ks_valid;
  logic             ks_ready;
  logic [31:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  logic [31:0] ks_src[$];
  logic [31:0] in_src[$];
  logic [31:0] obs_q[$];
  int          max_occ;

  snow3g_ks_xor #(.KS_DEPTH(KS_DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_len(msg_len),
    .ks_word(ks_word), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Runs one message against the model. ks_src/in_src hold the words to offer.
  task automatic run_msg(input int len, input bit rnd, input int hold, input int in_delay,
                         input bit extra_start, input int abort_at);
    int nw, tail, ks_idx, in_idx, out_idx, occ, hold_left;
    bit model_busy, pend, exp_done, ksv, inv, ordy, fire, pushm, acc, stalled, finished;
    bit aborted, exp_ksr;
    logic [31:0] exp_w[$];
    logic [31:0] m, prev_data;

    nw = (len + 31) / 32;
    tail = len % 32;
    for (int i = 0; i < nw; i++) begin
      m = 32'hFFFF_FFFF;
      if (i == nw - 1 && tail != 0) begin
        m = 32'h0;
        for (int b = 0; b < tail; b++) m[31-b] = 1'b1;
      end
      exp_w.push_back((ks_src[i] ^ in_src[i]) & m);
    end
    obs_q.delete();
    ks_idx = 0; in_idx = 0; out_idx = 0; occ = 0; max_occ = 0; hold_left = hold;
    pend = 0; stalled = 0; finished = 0; aborted = 0; prev_data = '0;

    @(negedge clk);
    start = 1'b1; msg_len = LEN_W'(len); ks_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if ({busy, ks_ready, in_ready, done} !== 4'b0000) begin
      $display("FAIL start_idle: busy/ks_ready/in_ready/done=%b required 0000",
               {busy, ks_ready, in_ready, done});
      errors++;
    end
    model_busy = (len != 0);
    exp_done = (len == 0);

    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      ksv = (ks_idx < ks_src.size()) && (!rnd || $urandom_range(0, 3) != 0);
      ks_valid = ksv;
      ks_word = ksv ? ks_src[ks_idx] : $urandom();
      inv = (in_idx < nw) && (cyc >= in_delay) && (!rnd || $urandom_range(0, 3) != 0);
      in_valid = inv;
      in_data = inv ? in_src[in_idx] : $urandom();
      if (hold_left > 0 && pend) begin
        ordy = 1'b0;
        hold_left--;
      end else begin
        ordy = !rnd || ($urandom_range(0, 2) != 0);
      end
      out_ready = ordy;
      start = extra_start && (cyc == 3);
      msg_len = start ? LEN_W'(8) : LEN_W'(len);
      #1;

      checks++;
      if (done !== exp_done) begin
        $display("FAIL done: got %b required %b (cycle %0d)", done, exp_done, cyc);
        errors++;
      end
      checks++;
      if (busy !== model_busy) begin
        $display("FAIL busy: got %b required %b (cycle %0d)", busy, model_busy, cyc);
        errors++;
      end
      checks++;
      if (out_valid !== pend) begin
        $display("FAIL out_valid: got %b required %b (cycle %0d)", out_valid, pend, cyc);
        errors++;
      end
      exp_ksr = model_busy && (occ < KS_DEPTH);
      checks++;
      if (ks_ready !== exp_ksr) begin
        $display("FAIL ks_ready: got %b required %b (occ %0d)", ks_ready, exp_ksr, occ);
        errors++;
      end
      fire = model_busy && inv && (occ > 0) && (!pend || ordy);
      checks++;
      if (in_ready !== fire) begin
        $display("FAIL in_ready: got %b required %b (cycle %0d)", in_ready, fire, cyc);
        errors++;
      end
      if (stalled) begin
        checks++;
        if (out_data !== prev_data) begin
          $display("FAIL out_stable: got %h required %h", out_data, prev_data);
          errors++;
        end
      end
      acc = pend && ordy;
      if (acc) begin
        checks++;
        if (out_data !== exp_w[out_idx] || out_last !== (out_idx == nw - 1)) begin
          $display("FAIL out_word%0d: got %h last %b required %h last %b", out_idx, out_data,
                   out_last, exp_w[out_idx], (out_idx == nw - 1));
          errors++;
        end
        obs_q.push_back(out_data);
      end
      if (exp_done) begin
        finished = 1'b1;
        break;
      end

      pushm = model_busy && ksv && (occ < KS_DEPTH);
      stalled = pend && !ordy;
      prev_data = out_data;
      ks_idx += int'(pushm);
      in_idx += int'(fire);
      occ = occ + int'(pushm) - int'(fire);
      if (occ > max_occ) max_occ = occ;
      if (acc) out_idx++;
      pend = fire ? 1'b1 : (acc ? 1'b0 : pend);
      exp_done = acc && (out_idx == nw);
      if (exp_done) begin
        model_busy = 1'b0;
        occ = 0;
      end
      if (abort_at >= 0 && out_idx >= abort_at) begin
        aborted = 1'b1;
        break;
      end
    end

    if (!finished && !aborted) begin
      checks++;
      errors++;
      $display("FAIL timeout: message len %0d incomplete, %0d of %0d words", len, out_idx, nw);
    end
    if (!aborted) begin
      ks_valid = 1'b0; in_valid = 1'b0; start = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL done_pulse: done %b busy %b required 0 0", done, busy);
        errors++;
      end
    end
  endtask

  task automatic fill_random(input int nks, input int nin);
    ks_src.delete();
    in_src.delete();
    for (int i = 0; i < nks; i++) ks_src.push_back($urandom());
    for (int i = 0; i < nin; i++) in_src.push_back($urandom());
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; msg_len = '0; ks_word = '0; ks_valid = 1'b1;
    in_data = '0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if ({out_data, out_valid, out_last, ks_ready, in_ready, busy, done} !== 38'h0) begin
      $display("FAIL reset_state: got data %h v%b l%b ksr%b inr%b busy%b done%b required 0",
               out_data, out_valid, out_last, ks_ready, in_ready, busy, done);
      errors++;
    end
    ks_valid = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_words();
    ks_src = '{32'hA5A5_A5A5, 32'h0F0F_0F0F};
    in_src = '{32'hFFFF_FFFF, 32'h1234_5678};
    run_msg(64, 1'b0, 0, 0, 1'b0, -1);
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 32'h5A5A_5A5A || obs_q[1] !== 32'h1D3B_5977) begin
      $display("FAIL full_words: got %0d words, first %h required 5a5a5a5a 1d3b5977",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 32'h0);
      errors++;
    end
  endtask

  task automatic test_partial_tail();
    ks_src = '{32'h0000_0000, 32'hFFFF_FFFF};
    in_src = '{32'h1111_1111, 32'hFFFF_FFFF};
    run_msg(40, 1'b0, 0, 0, 1'b0, -1);
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 32'h1111_1111 || obs_q[1] !== 32'h0) begin
      $display("FAIL tail40: got %0d words required 11111111 00000000", obs_q.size());
      errors++;
    end
    ks_src = '{$urandom(), 32'h0000_0000};
    in_src = '{$urandom(), 32'hFFFF_FFFF};
    run_msg(33, 1'b0, 0, 0, 1'b0, -1);
    checks++;
    if (obs_q.size() != 2 || obs_q[1] !== 32'h8000_0000) begin
      $display("FAIL tail33: got %h required 80000000", (obs_q.size() > 1) ? obs_q[1] : 32'h0);
      errors++;
    end
  endtask

  task automatic test_backpressure();
    fill_random(8, 4);
    run_msg(128, 1'b0, 5, 0, 1'b0, -1);
    checks++;
    if (max_occ != KS_DEPTH || obs_q.size() != 4) begin
      $display("FAIL backpressure: peak occupancy %0d words %0d required %0d 4", max_occ,
               obs_q.size(), KS_DEPTH);
      errors++;
    end
  endtask

  task automatic test_zero_len();
    ks_src.delete();
    in_src.delete();
    run_msg(0, 1'b0, 0, 0, 1'b0, -1);
  endtask

  task automatic test_ignored_start();
    fill_random(3, 3);
    run_msg(96, 1'b0, 0, 2, 1'b1, -1);
    checks++;
    if (obs_q.size() != 3) begin
      $display("FAIL ignored_start: got %0d words required 3", obs_q.size());
      errors++;
    end
  endtask

  task automatic test_flush();
    fill_random(5, 1);
    run_msg(32, 1'b0, 0, 6, 1'b0, -1);
    checks++;
    if (max_occ != KS_DEPTH) begin
      $display("FAIL flush_fill: peak occupancy %0d required %0d", max_occ, KS_DEPTH);
      errors++;
    end
    ks_src = '{32'hDEAD_BEEF};
    in_src = '{32'h0000_0000};
    run_msg(32, 1'b0, 0, 0, 1'b0, -1);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 32'hDEAD_BEEF) begin
      $display("FAIL flush: got %h required deadbeef", (obs_q.size() > 0) ? obs_q[0] : 32'h0);
      errors++;
    end
  endtask

  task automatic test_random();
    int len, nw;
    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(1, 300);
      nw = (len + 31) / 32;
      fill_random(nw + $urandom_range(0, 3), nw);
      run_msg(len, 1'b1, $urandom_range(0, 3), $urandom_range(0, 4), 1'b0, -1);
    end
  endtask

  task automatic test_reset_mid();
    fill_random(4, 3);
    run_msg(96, 1'b0, 0, 0, 1'b0, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_data, out_valid, out_last, ks_ready, in_ready, busy, done} !== 38'h0) begin
      $display("FAIL reset_mid: got data %h v%b l%b ksr%b inr%b busy%b done%b required 0",
               out_data, out_valid, out_last, ks_ready, in_ready, busy, done);
      errors++;
    end
    ks_valid = 1'b0; in_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL reset_no_done: done %b busy %b required 0 0", done, busy);
        errors++;
      end
    end
    fill_random(2, 2);
    run_msg(64, 1'b0, 0, 0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_partial_tail();
    test_backpressure();
    test_zero_len();
    test_ignored_start();
    test_flush();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
